rel_cmp_stage: RTL and testbench

REL_CMP_STAGE -- requirements
Module: rel_cmp_stage

---
 rtl/rel_cmp_stage.sv | 114 +++++++++++
 tb/tb_rel_cmp_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rel_cmp_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rel_cmp_stage                                                |
// | Brief   : Relational compare stage. Evaluates a <op> b on acceptance,  |
// |           queues {c, op, err} in a 2-entry in-order FIFO and keeps a   |
// |           saturating count of accepted true results.                   |
// |           Optional macro CMP_SIGNED_EN: two's-complement comparison.   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rel_cmp_stage #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic [2:0]       c_op,
  output logic             err,
  input  logic             clr,
  output logic [CNT_W-1:0] true_cnt
);

  localparam logic [1:0]       C_FULL    = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Operand views: the signed build reinterprets the same bits.
`ifdef CMP_SIGNED_EN
  logic signed [WIDTH-1:0] w_a;
  logic signed [WIDTH-1:0] w_b;
  assign w_a = $signed(a);
  assign w_b = $signed(b);
`else
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  assign w_a = a;
  assign w_b = b;
`endif

  logic       w_c;
  logic       w_err;
  logic       w_push;
  logic       w_pop;
  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [4:0] r_mem [0:1];

  // Evaluate the requested relation; illegal ops yield c=0 with err set.
  always_comb begin
    w_c   = 1'b0;
    w_err = 1'b0;
    case (op)
      3'd0:    w_c = (w_a <  w_b);
      3'd1:    w_c = (w_a >  w_b);
      3'd2:    w_c = (w_a <= w_b);
      3'd3:    w_c = (w_a >= w_b);
      3'd4:    w_c = (w_a == w_b);
      3'd5:    w_c = (w_a != w_b);
      default: w_err = 1'b1;
    endcase
  end

  // Handshakes are qualified only by registered occupancy, so a pop while
  // full cannot open in_ready in the same cycle.
  assign in_ready  = (r_count != C_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head entry drives the outputs; an empty FIFO presents zeros.
  assign {c, c_op, err} = out_valid ? r_mem[r_rd_ptr] : 5'd0;

  // Occupancy and pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
    end
  end

  // Entry storage, written with the result computed at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= 5'd0;
      r_mem[1] <= 5'd0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {w_c, op, w_err};
    end
  end

  // Saturating true-result counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      true_cnt <= '0;
    end else if (w_push && w_c && (true_cnt != C_CNT_MAX)) begin
      true_cnt <= true_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rel_cmp_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_rel_cmp_stage                                             |
// | Brief   : Scoreboard bench for rel_cmp_stage (handshake, ordering,     |
// |           illegal ops, counter saturation/clear, reset).               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_rel_cmp_stage;
  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready, clr;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       op;
  logic             in_ready, out_valid, c, err;
  logic [2:0]       c_op;
  logic [CNT_W-1:0] true_cnt;

  typedef struct packed {
    logic       c;
    logic [2:0] op;
    logic       err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned m_cnt;
  int          total = 0;
  int          bad = 0;

  rel_cmp_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .c_op(c_op), .err(err), .clr(clr), .true_cnt(true_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference relation using sign/zero extension to WIDTH+1 bits.
  function automatic exp_t ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [2:0] o);
    logic signed [WIDTH:0] sx, sy;
    exp_t e;
`ifdef CMP_SIGNED_EN
    sx = {x[WIDTH-1], x};
    sy = {y[WIDTH-1], y};
`else
    sx = {1'b0, x};
    sy = {1'b0, y};
`endif
    e.op  = o;
    e.err = (o > 3'd5);
    case (o)
      3'd0:    e.c = (sx <  sy);
      3'd1:    e.c = (sx >  sy);
      3'd2:    e.c = !(sx > sy);
      3'd3:    e.c = !(sx < sy);
      3'd4:    e.c = (sx == sy);
      3'd5:    e.c = !(sx == sy);
      default: e.c = 1'b0;
    endcase
    return e;
  endfunction

  // One clock: check visible state against the model, then advance both.
  task automatic step();
    exp_t e;
    bit   push, pop;
    #1;
    check("out_valid", out_valid, (sb_q.size() != 0));
    check("in_ready", in_ready, (sb_q.size() < 2));
    check("true_cnt", true_cnt, m_cnt);
    if (sb_q.size() != 0) begin
      check("c", c, sb_q[0].c);
      check("c_op", c_op, sb_q[0].op);
      check("err", err, sb_q[0].err);
    end
    push = in_valid && (sb_q.size() < 2);
    pop  = out_ready && (sb_q.size() != 0);
    e    = ref_model(a, b, op);
    if (rst) begin
      sb_q.delete();
      m_cnt = 0;
    end else begin
      if (pop)  void'(sb_q.pop_front());
      if (push) sb_q.push_back(e);
      if (clr) m_cnt = 0;
      else if (push && e.c && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [2:0] o);
    in_valid = v; a = x; b = y; op = o;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    a = '0; b = '0; op = '0;
    m_cnt = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_c", c, 0);
    check("rst_c_op", c_op, 0);
    check("rst_err", err, 0);
    check("rst_true_cnt", true_cnt, 0);

    // Single LT accept with immediate drain.
    out_ready = 1'b1;
    drive(1, 3'b000, 3'b101, 3'd0); step();
    drive(0, 0, 0, 0);
    #1;
    check("lt_out_valid", out_valid, 1);
    check("lt_c", c, 1);
    check("lt_err", err, 0);
    check("lt_true_cnt", true_cnt, 1);
    step();

    // GT where signedness matters, then illegal ops.
    drive(1, 3'b011, 3'b101, 3'd1); step();
    drive(1, 3'b000, 3'b000, 3'd6); step();
    drive(1, 3'b010, 3'b001, 3'd7); step();
    drive(0, 0, 0, 0); step(); step();

    // Backpressure: two fill the FIFO, third waits for in_ready.
    out_ready = 1'b0;
    drive(1, 3'd1, 3'd2, 3'd2); step();
    drive(1, 3'd4, 3'd4, 3'd4); step();
    drive(1, 3'd6, 3'd3, 3'd3); step(); step();
    out_ready = 1'b1; step(); step();
    drive(0, 0, 0, 0); step(); step(); step();

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drive(0, 0, 0, 0); out_ready = 1'b1; step(); step(); step();

    // Saturation: 260 true accepts from a cleared counter.
    clr = 1'b1; step(); clr = 1'b0;
    drive(1, 3'd0, 3'd1, 3'd0);
    for (int i = 0; i < 260; i++) step();
    #1;
    check("sat_true_cnt", true_cnt, 255);
    clr = 1'b1; step(); clr = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("clr_true_cnt", true_cnt, 0);
    step(); step();

    // Reset while full, with a push attempt in the same cycle.
    out_ready = 1'b0;
    drive(1, 3'd0, 3'd5, 3'd0); step(); step();
    rst = 1'b1; step();
    rst = 1'b0; drive(0, 0, 0, 0);
    #1;
    check("rst_full_out_valid", out_valid, 0);
    check("rst_full_in_ready", in_ready, 1);
    check("rst_full_true_cnt", true_cnt, 0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
